// File: rtl/led_blinker_bank_if.sv
// -----------------------------------------------------------------------------
// led_blinker_bank_if
// Configuration write channel for led_blinker_bank.
//   cfg_valid : master -> slave, write request
//   cfg_ready : slave -> master, block can accept a write
//   cfg_chan  : master -> slave, target channel
//   cfg_mode  : master -> slave, 00 off / 01 on / 10 blink / 11 pulse
//   cfg_half  : master -> slave, half-period or pulse length in ticks
// -----------------------------------------------------------------------------
interface led_blinker_bank_if #(
    parameter int CH_W     = 2,
    parameter int PERIOD_W = 8
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_half;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_half,
        output cfg_ready
    );
endinterface

// File: rtl/led_blinker_bank.sv
// -----------------------------------------------------------------------------
// led_blinker_bank
// Multi-channel LED blinker with a shared tick prescaler. Each channel runs
// off / on / blink / single-shot pulse with a runtime half-period in ticks.
//   CLOCK_50 : clock, rising edge
//   KEY      : synchronous active-high reset
//   cfg      : configuration write channel (slave modport)
//   tick     : one-cycle pulse every TICK_CYCLES clocks
//   LEDG     : LED drive, 1 = lit
//
// Channel state (per channel mode register):
//   state      | meaning
//   MODE_OFF   | LED held dark, ticks ignored
//   MODE_ON    | LED held lit, ticks ignored
//   MODE_BLINK | LED toggles every H ticks
//   MODE_PULSE | LED lit until the H-th tick, then falls back to MODE_OFF
// -----------------------------------------------------------------------------
module led_blinker_bank #(
    parameter int CHANNELS    = 4,
    parameter int TICK_CYCLES = 500000,
    parameter int PERIOD_W    = 8,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                KEY,
    led_blinker_bank_if.slave   cfg,
    output logic                tick,
    output logic [CHANNELS-1:0] LEDG
);

    localparam int              PC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } mode_e;

    logic [PC_W-1:0]     pc_q, pc_d;
    logic                tick_q, tick_d;
    logic                ready_q, ready_d;

    mode_e               mode_q [CHANNELS];
    mode_e               mode_d [CHANNELS];
    logic [PERIOD_W-1:0] half_q [CHANNELS];
    logic [PERIOD_W-1:0] half_d [CHANNELS];
    logic [PERIOD_W-1:0] cnt_q  [CHANNELS];
    logic [PERIOD_W-1:0] cnt_d  [CHANNELS];
    logic [PERIOD_W-1:0] last_cnt [CHANNELS];
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] wr_sel;
    logic                wr_en;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            pc_q    <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b0;
            led_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= MODE_OFF;
                half_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
            led_q   <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // ---------------------------------------------------------------- prescaler
    always_comb begin
        ready_d = 1'b1;
        if (pc_q == PC_LAST) begin
            pc_d   = '0;
            tick_d = 1'b1;
        end else begin
            pc_d   = pc_q + PC_W'(1);
            tick_d = 1'b0;
        end
    end

    // ------------------------------------------------------- write decode
    // Channel numbers >= CHANNELS match no wr_sel bit, so such writes
    // complete the handshake but are silently dropped.
    assign wr_en = cfg.cfg_valid && ready_q;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = wr_en && (cfg.cfg_chan == CH_W'(i));
        end
    end

    // Terminal count H-1, with half == 0 treated as H = 1.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            last_cnt[i] = (half_q[i] == '0) ? '0 : half_q[i] - PERIOD_W'(1);
        end
    end

    // --------------------------------------------------- channel next state
    // A write takes priority over a coincident tick on the same channel.
    always_comb begin
        led_d = led_q;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wr_sel[i]) begin
                mode_d[i] = mode_e'(cfg.cfg_mode);
                half_d[i] = cfg.cfg_half;
                cnt_d[i]  = '0;
                led_d[i]  = (cfg.cfg_mode != MODE_OFF);
            end else if (tick_q) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] == last_cnt[i]) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (cnt_q[i] == last_cnt[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        tick          = tick_q;
        LEDG          = led_q;
        cfg.cfg_ready = ready_q;
    end

endmodule

// File: doc/led_blinker_bank.md
# led_blinker_bank

Parametrised multi-channel LED blinker for the board's green LEDs, clocked from `CLOCK_50`. A shared prescaler generates a periodic `tick` (10 ms by default). Each channel has its own runtime-configurable mode and half-period, counted in ticks. Channels support off, steady on, continuous blink and single-shot pulse. The block replaces per-LED fixed one-second toggle logic and sits between the board top level (`CLOCK_50`, `KEY`, `LEDG`) and whatever control logic writes LED configurations.

## Interface

Parameters:
- `CHANNELS`, 4: number of LED channels (1..8).
- `TICK_CYCLES`, 500000: clocks per tick (≥2); 500000 gives 10 ms at 50 MHz.
- `PERIOD_W`, 8: width of the per-channel half-period, in ticks.
- `CH_W`, clog2(CHANNELS), minimum 1: width of the channel select.

Ports:
- `CLOCK_50`, in, 1: sole clock; all logic on its rising edge.
- `KEY`, in, 1: synchronous, active-high reset.
- `cfg_valid`, in, 1: configuration write request.
- `cfg_ready`, out, 1: block can accept a write.
- `cfg_chan`, in, CH_W: target channel.
- `cfg_mode`, in, 2: 00 = off, 01 = on, 10 = blink, 11 = pulse.
- `cfg_half`, in, PERIOD_W: half-period, or pulse length, in ticks.
- `tick`, out, 1: one-cycle pulse, once per TICK_CYCLES clocks.
- `LEDG`, out, CHANNELS: LED drive, 1 = lit.

## Operation

- **Prescaler.** Counter `pc` counts 0..TICK_CYCLES-1. When `pc == TICK_CYCLES-1` it wraps to 0. `tick` is registered high on the clock edge where `pc` wraps and is high for exactly that one following cycle.
- **Per-channel registers.** Each channel holds `mode[1:0]`, `half[PERIOD_W-1:0]`, `cnt[PERIOD_W-1:0]` and `led` (drives `LEDG[i]`). The effective half-period is `H = (half == 0) ? 1 : half`.
- **Write handshake.** A write is accepted when `cfg_valid && cfg_ready` is sampled on an edge.
  - The accepted write loads `mode` and `half` for `cfg_chan` and clears `cnt`.
  - `led` is set to 0 for mode off and to 1 for on, blink and pulse.
  - `cfg_chan >= CHANNELS`: the handshake completes but the write is dropped with no state change.
- **Mode off / on.** `led` is held at 0 / 1; ticks are ignored and `cnt` stays 0.
- **Mode blink.** Evaluated on each tick:
  - If `cnt == H-1`, then `cnt` ← 0 and `led` toggles.
  - Otherwise `cnt` increments.
  - Result: `led` toggles on every H-th tick after the load; the full period is 2·H ticks.
- **Mode pulse.** Evaluated on each tick:
  - If `cnt == H-1`, then `led` ← 0, `mode` ← off and `cnt` ← 0.
  - Otherwise `cnt` increments.
  - Result: the LED is lit from the load until the H-th tick after the load, then stays off.
- **Arithmetic.** `cnt` never exceeds H-1, so there is no overflow at `half = 2^PERIOD_W - 1`.
- **Simultaneous events.**
  - Write and tick on the same channel in the same cycle: the write wins and that tick is not counted.
  - Other channels process the tick normally.
- **Reset (`KEY=1`).** On the next edge the block clears `pc`, `tick`, every `mode`/`half`/`cnt`/`led`, and `cfg_ready`.
  - Reset mid-blink or mid-pulse discards all state.
  - Writes presented during reset are ignored.

## Timing

- Reset values: `LEDG=0`, `tick=0`, `cfg_ready=0`. `cfg_ready` is registered and rises 1 cycle after `KEY` is released; after that it stays 1 until the next reset.
- Write latency: `LEDG[cfg_chan]` takes its new value on the edge that accepts the write, i.e. it is visible 1 cycle after `cfg_valid` is sampled.
- Tick timing: the first `tick` after reset release is high in cycle TICK_CYCLES, counting the first non-reset edge as cycle 1. Subsequent ticks are exactly TICK_CYCLES apart.
- LED update on tick: a tick-caused LED change is registered on the edge that samples `tick` high, so it lands 1 cycle after `tick`.
- No combinational path from any input to any output.

## Test plan

Bench parameters: `TICK_CYCLES=4`, `CHANNELS=4`, `PERIOD_W=4`.

1. **Reset.** Hold `KEY=1` for 3 cycles, then release → `LEDG=0000`, `tick=0` and `cfg_ready=0` during reset; `cfg_ready=1` 1 cycle after release; `tick` high every 4th cycle from then on.
2. **Blink.** Write ch0, mode 10, half=2 → `LEDG[0]=1` next cycle, then toggles 1 cycle after every 2nd tick, i.e. every 8 clocks; other LEDs stay 0.
3. **Pulse.** Write ch1, mode 11, half=3 → `LEDG[1]` high until 1 cycle after the 3rd subsequent tick, then 0 permanently. A read-back of the internal mode (via hierarchy) shows off.
4. **Boundaries.**
   - half=0 on ch2 in blink → toggles every tick.
   - half=15 → toggles every 15 ticks, with no glitch at wrap.
   - Variant with `CHANNELS=3`: a write with `cfg_chan=3` changes nothing.
5. **Collision.** Write ch0 blink half=1 in the exact cycle `tick` is high → `LEDG[0]=1` and `cnt=0`; the first toggle occurs on the next tick, not that one.
6. **Reset mid-operation.** With ch0 blinking and ch1 pulsing, assert `KEY` for 1 cycle → `LEDG=0000` next cycle, prescaler restarts, and channels stay off until rewritten.
